// File: rtl/zvc_pkg.sv
`default_nettype none
// ============================================================================
// Package  : zvc_pkg
// Brief    : Shared geometry and mask polarity for the ZV compressor and
//            decompressor pair.
// Revision : 1.0 - initial release
// ============================================================================
package zvc_pkg;

    localparam int LANES = 128;
    localparam int IDX_W = 7;
    localparam int CNT_W = 8;

    // A set mask bit marks a lane that was zero in the original line.
    localparam logic ZVC_MASK_ZERO = 1'b1;

    function automatic int ent_w(input int dist_width, input int max_lifm_rsiz);
        return dist_width * max_lifm_rsiz;
    endfunction

endpackage : zvc_pkg
`default_nettype wire

// File: rtl/zvc_expand_gather.sv
`default_nettype none
// ============================================================================
// Module   : zvc_expand_gather
// Brief    : Combinational re-expansion of packed LIFM/MT data to lane order.
// Revision : 1.0 - initial release
// ============================================================================
module zvc_expand_gather #(
    parameter int LANES      = 128,
    parameter int WORD_WIDTH = 8,
    parameter int ENT_W      = 28,
    parameter int IDX_W      = 7
) (
    input  logic [LANES-1:0]            mask,
    input  logic [LANES*IDX_W-1:0]      src_idx,
    input  logic [LANES*WORD_WIDTH-1:0] lifm_comp,
    input  logic [LANES*ENT_W-1:0]      mt_comp,
    output logic [LANES*WORD_WIDTH-1:0] lifm_line,
    output logic [LANES*ENT_W-1:0]      mt_line
);

    import zvc_pkg::*;

    // Each lane is an independent LANES-way mux steered by its own source index.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [IDX_W-1:0] w_idx;
        logic             w_zero;

        assign w_idx  = src_idx[i*IDX_W +: IDX_W];
        assign w_zero = (mask[i] == ZVC_MASK_ZERO);

        assign lifm_line[i*WORD_WIDTH +: WORD_WIDTH] =
            w_zero ? '0 : lifm_comp[w_idx*WORD_WIDTH +: WORD_WIDTH];
        assign mt_line[i*ENT_W +: ENT_W] =
            w_zero ? '0 : mt_comp[w_idx*ENT_W +: ENT_W];
    end

endmodule : zvc_expand_gather
`default_nettype wire

// File: rtl/zvc_decompressor.sv
`default_nettype none
// ============================================================================
// Module   : zvc_decompressor
// Brief    : Two-stage valid/ready pipeline that restores zero-compressed
//            LIFM/MT lines to their original lane positions.
// Revision : 1.0 - initial release
// ============================================================================
module zvc_decompressor #(
    parameter  int LANES         = zvc_pkg::LANES,
    parameter  int WORD_WIDTH    = 8,
    parameter  int DIST_WIDTH    = 7,
    parameter  int MAX_LIFM_RSIZ = 4,
    localparam int ENT_W         = zvc_pkg::ent_w(DIST_WIDTH, MAX_LIFM_RSIZ)
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES-1:0]              in_mask,
    input  logic [zvc_pkg::CNT_W-1:0]     in_nnz,
    input  logic [LANES*WORD_WIDTH-1:0]   lifm_comp,
    input  logic [LANES*ENT_W-1:0]        mt_comp,

    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*WORD_WIDTH-1:0]   lifm_line,
    output logic [LANES*ENT_W-1:0]        mt_line,
    output logic [zvc_pkg::CNT_W-1:0]     out_nnz,
    output logic                          out_err
);

    import zvc_pkg::*;

    localparam int LEVELS = $clog2(LANES);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_v;
    logic r_s2_v;
    logic w_s1_adv;
    logic w_in_xfer;

    assign w_s1_adv  = !r_s2_v || out_ready;
    assign in_ready  = !r_s1_v || w_s1_adv;
    assign w_in_xfer = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Prefix count of non-zero lanes: Sklansky-form Ladner-Fischer tree.
    // At level k every lane in the upper half of a 2^(k+1) block adds the
    // running total of the last lane of the lower half.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]       w_scan [0:LEVELS][LANES];
    logic [LANES*IDX_W-1:0] w_src_idx;
    logic [CNT_W-1:0]       w_nnz;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_scan[0][i] = CNT_W'(in_mask[i] != ZVC_MASK_ZERO);
        end
        for (int k = 0; k < LEVELS; k++) begin
            for (int i = 0; i < LANES; i++) begin
                if (((i >> k) & 1) == 1) begin
                    w_scan[k+1][i] = w_scan[k][i] + w_scan[k][((i >> k) << k) - 1];
                end else begin
                    w_scan[k+1][i] = w_scan[k][i];
                end
            end
        end
        // Inclusive minus own bit gives the exclusive count, always < LANES.
        for (int i = 0; i < LANES; i++) begin
            w_src_idx[i*IDX_W +: IDX_W] = IDX_W'(w_scan[LEVELS][i] - w_scan[0][i]);
        end
        w_nnz = w_scan[LEVELS][LANES-1];
    end

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [LANES-1:0]            r_s1_mask;
    logic [LANES*IDX_W-1:0]      r_s1_src_idx;
    logic [LANES*WORD_WIDTH-1:0] r_s1_lifm;
    logic [LANES*ENT_W-1:0]      r_s1_mt;
    logic [CNT_W-1:0]            r_s1_nnz;
    logic                        r_s1_err;

    // ------------------------------------------------------------------
    // Expansion between stage 1 and stage 2
    // ------------------------------------------------------------------
    logic [LANES*WORD_WIDTH-1:0] w_lifm_exp;
    logic [LANES*ENT_W-1:0]      w_mt_exp;

    zvc_expand_gather #(
        .LANES      (LANES),
        .WORD_WIDTH (WORD_WIDTH),
        .ENT_W      (ENT_W),
        .IDX_W      (IDX_W)
    ) u_gather (
        .mask      (r_s1_mask),
        .src_idx   (r_s1_src_idx),
        .lifm_comp (r_s1_lifm),
        .mt_comp   (r_s1_mt),
        .lifm_line (w_lifm_exp),
        .mt_line   (w_mt_exp)
    );

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------
    logic [LANES*WORD_WIDTH-1:0] r_lifm_line;
    logic [LANES*ENT_W-1:0]      r_mt_line;
    logic [CNT_W-1:0]            r_out_nnz;
    logic                        r_out_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_v       <= 1'b0;
            r_s1_mask    <= '0;
            r_s1_src_idx <= '0;
            r_s1_lifm    <= '0;
            r_s1_mt      <= '0;
            r_s1_nnz     <= '0;
            r_s1_err     <= 1'b0;
            r_s2_v       <= 1'b0;
            r_lifm_line  <= '0;
            r_mt_line    <= '0;
            r_out_nnz    <= '0;
            r_out_err    <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_v <= in_valid;
            end
            if (w_in_xfer) begin
                r_s1_mask    <= in_mask;
                r_s1_src_idx <= w_src_idx;
                r_s1_lifm    <= lifm_comp;
                r_s1_mt      <= mt_comp;
                r_s1_nnz     <= w_nnz;
                r_s1_err     <= (w_nnz != in_nnz);
            end
            if (w_s1_adv) begin
                r_s2_v <= r_s1_v;
            end
            // Output data only changes when a real line moves in, so a
            // stalled line stays put and idle cycles leave the bus quiet.
            if (w_s1_adv && r_s1_v) begin
                r_lifm_line <= w_lifm_exp;
                r_mt_line   <= w_mt_exp;
                r_out_nnz   <= r_s1_nnz;
                r_out_err   <= r_s1_err;
            end
        end
    end

    assign out_valid = r_s2_v;
    assign lifm_line = r_lifm_line;
    assign mt_line   = r_mt_line;
    assign out_nnz   = r_out_nnz;
    assign out_err   = r_out_err;

endmodule : zvc_decompressor
`default_nettype wire

// File: tb/tb_zvc_decompressor.sv
`default_nettype none
// ============================================================================
// Module   : tb_zvc_decompressor
// Brief    : Scoreboard bench for zvc_decompressor with a lane-walk reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zvc_decompressor;

    localparam int L = 128;
    localparam int W = 8;
    localparam int E = 28;

    typedef struct {
        logic [L*W-1:0] lifm;
        logic [L*E-1:0] mt;
        logic [7:0]     nnz;
        logic           err;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [L-1:0]   in_mask;
    logic [7:0]     in_nnz;
    logic [L*W-1:0] lifm_comp;
    logic [L*E-1:0] mt_comp;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] lifm_line;
    logic [L*E-1:0] mt_line;
    logic [7:0]     out_nnz;
    logic           out_err;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic rand_ready = 1'b0;
    logic forced_ready = 1'b1;

    zvc_decompressor dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mask   (in_mask),
        .in_nnz    (in_nnz),
        .lifm_comp (lifm_comp),
        .mt_comp   (mt_comp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .lifm_line (lifm_line),
        .mt_line   (mt_line),
        .out_nnz   (out_nnz),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    // Reference: walk lanes in order, handing out packed entries to non-zero lanes.
    function automatic exp_t model(input logic [L-1:0] m, input logic [L*W-1:0] lc,
                                   input logic [L*E-1:0] mc, input logic [7:0] n);
        exp_t e;
        int   j = 0;
        e.lifm = '0;
        e.mt   = '0;
        for (int i = 0; i < L; i++) begin
            if (!m[i]) begin
                e.lifm[i*W +: W] = lc[j*W +: W];
                e.mt[i*E +: E]   = mc[j*E +: E];
                j++;
            end
        end
        e.nnz = 8'(j);
        e.err = (j != int'(n));
        return e;
    endfunction

    function automatic int diff_w(input logic [L*W-1:0] a, input logic [L*W-1:0] b);
        for (int i = 0; i < L; i++) if (a[i*W +: W] !== b[i*W +: W]) return i;
        return 0;
    endfunction

    function automatic int diff_e(input logic [L*E-1:0] a, input logic [L*E-1:0] b);
        for (int i = 0; i < L; i++) if (a[i*E +: E] !== b[i*E +: E]) return i;
        return 0;
    endfunction

    function automatic logic [L*W-1:0] rand_lifm();
        logic [L*W-1:0] r;
        for (int i = 0; i < L*W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [L*E-1:0] rand_mt();
        logic [L*E-1:0] r;
        for (int i = 0; i < L*E/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, want);
        end
    endtask

    // Single owner of out_ready; updated after the input driver each cycle.
    always @(posedge clk) begin
        #2;
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
    end

    // Monitor: pops on every output transfer and checks hold-while-stalled.
    logic           stalled = 1'b0;
    logic [L*W-1:0] hold_lifm;
    logic [L*E-1:0] hold_mt;
    logic [7:0]     hold_nnz;
    logic           hold_err;
    exp_t           got_e;

    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                n_vec++;
                if (!out_valid || lifm_line !== hold_lifm || mt_line !== hold_mt ||
                    out_nnz !== hold_nnz || out_err !== hold_err) begin
                    n_err++;
                    $display("FAIL hold_stable: out_valid=%0b nnz=%0d err=%0b, held nnz=%0d err=%0b",
                             out_valid, out_nnz, out_err, hold_nnz, hold_err);
                end
            end
            stalled = 1'b0;
            if (out_valid) begin
                if (!out_ready) begin
                    stalled   = 1'b1;
                    hold_lifm = lifm_line;
                    hold_mt   = mt_line;
                    hold_nnz  = out_nnz;
                    hold_err  = out_err;
                end else if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_line: out_valid=1 with nnz=%0d, expected no line", out_nnz);
                end else begin
                    got_e = sb.pop_front();
                    n_vec++;
                    if (lifm_line !== got_e.lifm) begin
                        n_err++;
                        $display("FAIL lifm_line lane %0d: got %h, expected %h", diff_w(lifm_line, got_e.lifm),
                                 lifm_line[diff_w(lifm_line, got_e.lifm)*W +: W],
                                 got_e.lifm[diff_w(lifm_line, got_e.lifm)*W +: W]);
                    end
                    n_vec++;
                    if (mt_line !== got_e.mt) begin
                        n_err++;
                        $display("FAIL mt_line lane %0d: got %h, expected %h", diff_e(mt_line, got_e.mt),
                                 mt_line[diff_e(mt_line, got_e.mt)*E +: E],
                                 got_e.mt[diff_e(mt_line, got_e.mt)*E +: E]);
                    end
                    n_vec++;
                    if (out_nnz !== got_e.nnz) begin
                        n_err++;
                        $display("FAIL out_nnz: got %0d, expected %0d", out_nnz, got_e.nnz);
                    end
                    n_vec++;
                    if (out_err !== got_e.err) begin
                        n_err++;
                        $display("FAIL out_err: got %0b, expected %0b", out_err, got_e.err);
                    end
                end
            end
        end
    end

    task automatic present(input logic [L-1:0] m, input logic [L*W-1:0] lc,
                           input logic [L*E-1:0] mc, input logic [7:0] n);
        in_mask   = m;
        lifm_comp = lc;
        mt_comp   = mc;
        in_nnz    = n;
        in_valid  = 1'b1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic wait_accept();
        int cyc = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(in_mask, lifm_comp, mt_comp, in_nnz));
                break;
            end
            cyc++;
            if (cyc > 200) begin
                n_vec++;
                n_err++;
                $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", cyc);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_beat(input logic [L-1:0] m, input logic [L*W-1:0] lc,
                             input logic [L*E-1:0] mc, input logic [7:0] n);
        present(m, lc, mc, n);
        wait_accept();
    endtask

    task automatic wait_empty();
        int cyc = 0;
        while (sb.size() != 0 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_lifm_zero"}, 32'(lifm_line != '0), 32'd0);
        chk({tag, "_mt_zero"}, 32'(mt_line != '0), 32'd0);
        chk({tag, "_out_nnz"}, 32'(out_nnz), 32'd0);
        chk({tag, "_out_err"}, 32'(out_err), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [L-1:0]   m;
        logic [L*W-1:0] lc;
        logic [L*E-1:0] mc;
        logic [7:0]     n;
        int             mode;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_mask   = '0;
        in_nnz    = '0;
        lifm_comp = '0;
        mt_comp   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("reset");
        @(posedge clk);
        #1;

        // Identity copy with a 2-cycle latency check.
        for (int i = 0; i < L; i++) lc[i*W +: W] = 8'(i + 1);
        send_beat('0, lc, rand_mt(), 8'd128);
        @(negedge clk);
        chk("latency_cycle1_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("latency_cycle2_valid", 32'(out_valid), 32'd1);
        chk("identity_lane127", 32'(lifm_line[127*W +: W]), 32'd128);
        @(posedge clk);
        #1;

        // All lanes zero, packed data is garbage.
        send_beat('1, {(L*W/8){8'hFF}}, {(L*E/4){4'hF}}, 8'd0);

        // Even lanes zero: odd lane 2k+1 carries 0xA0+k.
        lc = rand_lifm();
        for (int k = 0; k < 64; k++) lc[k*W +: W] = 8'(8'hA0 + k);
        for (int i = 0; i < L; i++) m[i] = (i % 2 == 0);
        send_beat(m, lc, rand_mt(), 8'd64);

        // Count mismatch: nine non-zero lanes, sender claims ten.
        m = '1;
        for (int k = 0; k < 9; k++) m[k*13 + 2] = 1'b0;
        send_beat(m, rand_lifm(), rand_mt(), 8'd10);
        wait_empty();

        // Back-pressure: two beats fill the pipe, the third must wait.
        forced_ready = 1'b0;
        send_beat($urandom, rand_lifm(), rand_mt(), 8'd0);
        send_beat('0, rand_lifm(), rand_mt(), 8'd128);
        m = {$urandom, $urandom, $urandom, $urandom};
        present(m, rand_lifm(), rand_mt(), 8'($countones(~m)));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        forced_ready = 1'b1;
        wait_accept();
        wait_empty();

        // Reset with both stages holding lines.
        forced_ready = 1'b0;
        send_beat('0, rand_lifm(), rand_mt(), 8'd128);
        send_beat($urandom, rand_lifm(), rand_mt(), 8'd7);
        idle(1);
        reset = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_quiet("midreset");
        @(posedge clk);
        #1;
        forced_ready = 1'b1;
        idle(10);

        // Randomized traffic with random back-pressure and idle gaps.
        rand_ready = 1'b1;
        for (int b = 0; b < 300; b++) begin
            mode = $urandom_range(0, 4);
            for (int i = 0; i < L; i++) begin
                case (mode)
                    0:       m[i] = 1'b0;
                    1:       m[i] = 1'b1;
                    2:       m[i] = 1'($urandom_range(0, 1));
                    3:       m[i] = ($urandom_range(0, 7) != 0);
                    default: m[i] = ($urandom_range(0, 7) == 0);
                endcase
            end
            n = 8'($countones(~m));
            if ($urandom_range(0, 7) == 0) n = n + 8'd1;
            send_beat(m, rand_lifm(), rand_mt(), n);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        rand_ready   = 1'b0;
        forced_ready = 1'b1;
        idle(1);
        wait_empty();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_zvc_decompressor
`default_nettype wire
